// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the core's instruction memory
//
// Accepts a little-endian byte stream (16-bit word count N, then 4*N payload
// bytes), assembles 32-bit words and writes them to instruction memory from
// word address 0. The core is held in reset until the image is complete.
//
// Optional feature macro: LOADER_CHECKSUM_EN. When defined, one trailing
// checksum byte (XOR of all payload bytes) is required before release.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   rx_valid    input byte present
//   rx_data     input byte
//   rx_ready    loader can accept a byte (combinational from state)
//   imem_we     instruction-memory write strobe, one cycle per word
//   imem_addr   word address being written
//   imem_wdata  word being written
//   core_rst    core reset; high while loading or in error
//   done        image loaded, core running
//   error       load failed; sticky until rst
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_RUN, S_ERR} state_t;
`endif

  // Memory capacity in words; a count equal to this is legal and fills memory.
  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        len_lo;
  logic [15:0]       n_words;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [23:0]       word_buf;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic        accept;
  logic [15:0] count;
  logic        last_word;

  assign accept = rx_valid & rx_ready;
  assign count  = {rx_data, len_lo};
  // Compare index+1 against N so that N == CAP needs no extra index bit.
  assign last_word = (17'(word_idx) + 17'd1) == {1'b0, n_words};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LEN0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    case (state)
      S_LEN0: begin
        rx_ready = 1'b1;
        if (accept) state_nxt = S_LEN1;
      end
      S_LEN1: begin
        rx_ready = 1'b1;
        if (accept) begin
          if (count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_nxt = S_CSUM;
`else
            state_nxt = S_RUN;
`endif
          end else if ({1'b0, count} > CAP) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (accept && byte_cnt == 2'd3 && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_RUN;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        if (accept) state_nxt = (rx_data == csum) ? S_RUN : S_ERR;
      end
`endif
      S_RUN: state_nxt = S_RUN;
      S_ERR: state_nxt = S_ERR;
      default: state_nxt = S_LEN0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo     <= '0;
      n_words    <= '0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      word_buf   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we  <= 1'b0;
      // Registered from the current state so release lands on the same edge
      // that memory samples the final write.
      core_rst <= (state != S_RUN);
      done     <= (state == S_RUN);
      error    <= error | (state_nxt == S_ERR);

      if (state == S_LEN0 && accept) len_lo  <= rx_data;
      if (state == S_LEN1 && accept) n_words <= count;

      if (state == S_DATA && accept) begin
        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum <= csum ^ rx_data;
`endif
        if (byte_cnt == 2'd3) begin
          imem_we    <= 1'b1;
          imem_addr  <= word_idx;
          imem_wdata <= {rx_data, word_buf};
          word_idx   <= word_idx + 1'b1;
        end else begin
          // Shift right so b0 ends up in the low byte after three bytes.
          word_buf <= {rx_data, word_buf[23:8]};
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

  localparam int ADDR_W = 4;
  localparam int CAP    = 1 << ADDR_W;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem[CAP];
  int          wr_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: one write per cycle with imem_we high, sequential addresses.
  always @(negedge clk) begin
    if (imem_we) begin
      check("wr_addr_seq", 32'(imem_addr), wr_cnt);
      mem[imem_addr] = imem_wdata;
      wr_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    wr_cnt = 0;
    for (int i = 0; i < CAP; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  // Called at a negedge; byte is accepted at the following posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    check("rx_ready_at_byte", rx_ready, 1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // Reference stream: count, little-endian payload, optional XOR checksum.
  task automatic build(input wq_t ws, output bq_t s);
    logic [7:0] x;
    logic [15:0] n;
    logic [31:0] w;
    s = {};
    x = 8'h00;
    n = 16'(ws.size());
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    foreach (ws[i]) begin
      w = ws[i];
      for (int k = 0; k < 4; k++) begin
        s.push_back(w[8*k +: 8]);
        x ^= w[8*k +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    s.push_back(x);
`endif
  endtask

  task automatic send_stream(input bq_t s, input int min_gap, input int max_gap);
    for (int i = 0; i < s.size() - 1; i++) send_byte(s[i], $urandom_range(max_gap, min_gap));
    send_byte(s[s.size()-1], 0);
  endtask

  task automatic run_good(input string tag, input wq_t ws, input int min_gap, input int max_gap);
    bq_t s;
    int  n;
    n = ws.size();
    build(ws, s);
    send_stream(s, min_gap, max_gap);
`ifndef LOADER_CHECKSUM_EN
    if (n > 0) check({tag, "_last_we"}, imem_we, 1);
`endif
    check({tag, "_core_rst_hold"}, core_rst, 1);
    check({tag, "_done_early"}, done, 0);
    @(negedge clk);
    check({tag, "_core_rst_rel"}, core_rst, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_error"}, error, 0);
    check({tag, "_rx_ready_run"}, rx_ready, 0);
    repeat (3) @(negedge clk);
    check({tag, "_wr_cnt"}, wr_cnt, n);
    for (int i = 0; i < n; i++) check({tag, "_word"}, mem[i], ws[i]);
  endtask

  initial begin
    wq_t ws;
    bq_t s;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    wr_cnt   = 0;

    do_reset();
    check_reset_state("reset");

    // Two-instruction image from the test plan.
    ws = {};
    ws.push_back(32'h00A00513);
    ws.push_back(32'h00100593);
    run_good("n2", ws, 0, 0);

    // Empty image.
    do_reset();
    ws = {};
    run_good("n0", ws, 0, 0);

    // Oversized count: 17 words into a 16-word memory.
    do_reset();
    send_byte(8'h11, 0);
    send_byte(8'h00, 0);
    check("ovf_error", error, 1);
    @(negedge clk);
    check("ovf_error_hold", error, 1);
    check("ovf_rx_ready", rx_ready, 0);
    check("ovf_core_rst", core_rst, 1);
    check("ovf_done", done, 0);
    repeat (3) @(negedge clk);
    check("ovf_wr_cnt", wr_cnt, 0);

    // Single word with two idle cycles between every byte.
    do_reset();
    ws = {};
    ws.push_back($urandom);
    run_good("n1_gaps", ws, 2, 2);

    // Abort mid-word, then a fresh stream straight after reset.
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    do_reset();
    check_reset_state("abort");
    ws = {};
    ws.push_back($urandom);
    ws.push_back($urandom);
    ws.push_back($urandom);
    run_good("after_abort", ws, 0, 1);

    // Reset while running restarts loading.
    do_reset();
    check_reset_state("rst_in_run");

    // Full memory.
    ws = {};
    for (int i = 0; i < CAP; i++) ws.push_back($urandom);
    run_good("full", ws, 0, 2);

    // Random images.
    for (int t = 0; t < 8; t++) begin
      int n;
      do_reset();
      n  = $urandom_range(CAP, 1);
      ws = {};
      for (int i = 0; i < n; i++) ws.push_back($urandom);
      run_good("rand", ws, 0, 3);
    end

`ifdef LOADER_CHECKSUM_EN
    // Corrupted checksum byte.
    do_reset();
    ws = {};
    for (int i = 0; i < 3; i++) ws.push_back($urandom);
    build(ws, s);
    s[s.size()-1] = s[s.size()-1] ^ 8'h5A;
    send_stream(s, 0, 1);
    @(negedge clk);
    check("csum_error", error, 1);
    check("csum_done", done, 0);
    check("csum_core_rst", core_rst, 1);
    check("csum_rx_ready", rx_ready, 0);
    check("csum_wr_cnt", wr_cnt, 3);
    for (int i = 0; i < 3; i++) check("csum_word", mem[i], ws[i]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
